// File: rtl/apb_pkg.sv
// Shared state encoding, default widths and strobe-width helper for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_DATA_SIZE = 32;
  localparam int APB_ADDR_SIZE = 6;
  localparam int APB_BYTE_BITS = 8;

  function automatic int strb_width(input int data_size);
    return data_size / APB_BYTE_BITS;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; flags the cycle whose increment would reach LIMIT.
module apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic increment,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (increment && (count_q != CNT_W'(LIMIT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Abort fires on the edge where this wait cycle would make the count hit LIMIT.
  assign expired = increment && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB4 master bridge, one transfer in flight.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_SIZE      = APB_DATA_SIZE,
  parameter int ADDR_SIZE      = APB_ADDR_SIZE,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_SIZE     = strb_width(DATA_SIZE)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [DATA_SIZE-1:0] cmd_wdata,
  input  logic [STRB_SIZE-1:0] cmd_strb,
  output logic                 rsp_valid,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_SIZE-1:0] PADDR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [DATA_SIZE-1:0] PWDATA,
  output logic [STRB_SIZE-1:0] PSTROBE,
  input  logic [DATA_SIZE-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  apb_state_e state_q, state_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_SIZE-1:0] paddr_q, paddr_d;
  logic [DATA_SIZE-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [STRB_SIZE-1:0] pstrobe_q, pstrobe_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic accept, timeout_hit;

  assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clear     (state_q == SETUP),
    .increment ((state_q == ACCESS) && !PREADY),
    .expired   (timeout_hit)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrobe_d   = pstrobe_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // Completion wins over a timeout landing in the same cycle.
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          if (!pwrite_q) rsp_rdata_d = PRDATA;
          state_d = accept ? SETUP : IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      paddr_d   = cmd_addr;
      pwrite_d  = cmd_write;
      pwdata_d  = cmd_wdata;
      pstrobe_d = cmd_write ? cmd_strb : '0;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrobe_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrobe_q   <= pstrobe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTROBE   = pstrobe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural memory slave, queued requester, transaction-level
// reference model compared every cycle, plus directed literal checks. Honours APB_TIMEOUT_EN.
module tb_apb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int SW = 4;
  localparam int TO = 4;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;
  logic [SW-1:0] PSTROBE;
  logic [DW-1:0] PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;

  apb_master_bridge #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTROBE(PSTROBE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } cmd_t;

  function automatic cmd_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s);
    cmd_t c;
    c.w = w; c.a = a; c.d = d; c.s = s;
    return c;
  endfunction

  // Slave: memory with selectable wait/error behaviour.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  int slave_mode = 0;
  int slave_waits = 0;
  int err_mode = 0;
  int acc_cnt = 0;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      case (slave_mode)
        0: PREADY = 1'b1;
        1: PREADY = (acc_cnt >= slave_waits);
        2: PREADY = ($urandom_range(0, 2) != 0);
        default: PREADY = 1'b0;
      endcase
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY = (slave_mode == 2) ? 1'($urandom_range(0, 1)) : (slave_mode == 0);
    end
    case (err_mode)
      1: PSLVERR = 1'b1;
      2: PSLVERR = ($urandom_range(0, 3) == 0);
      default: PSLVERR = 1'b0;
    endcase
    PRDATA = mem[PADDR];
  end

  always @(posedge PCLK)
    if (PRESETn && PSEL && PENABLE && PREADY && PWRITE)
      mem[PADDR] = merge(mem[PADDR], PWDATA, PSTROBE);

  // Requester: presents queued commands, holding each until the handshake.
  cmd_t cmd_q[$];
  int cyc = 0;
  bit acc_seen = 0;
  bit mark_first = 0;
  int last_acc_cyc = 0;
  int first_acc_cyc = 0;
  int req_rate = 100;

  always @(posedge PCLK) begin
    cyc++;
    acc_seen = PRESETn && cmd_valid && cmd_ready;
    if (acc_seen) begin
      last_acc_cyc = cyc;
      if (mark_first) begin first_acc_cyc = cyc; mark_first = 0; end
    end
  end

  always @(negedge PCLK) begin
    cmd_t c;
    if (acc_seen) begin cmd_valid = 1'b0; acc_seen = 0; end
    if (!cmd_valid && cmd_q.size() > 0 && $urandom_range(0, 99) < req_rate) begin
      c = cmd_q.pop_front();
      cmd_write = c.w; cmd_addr = c.a; cmd_wdata = c.d; cmd_strb = c.s;
      cmd_valid = 1'b1;
    end else if (!cmd_valid) begin
      cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_strb = SW'($urandom);
    end
  end

  // Reference model: tracks one outstanding transfer by edges elapsed since acceptance.
  bit m_busy = 0;
  int m_k = 0;
  int m_wait = 0;
  cmd_t m_cur;
  logic exp_psel = 0, exp_pen = 0, exp_pwrite = 0, exp_rv = 0, exp_err = 0;
  logic [AW-1:0] exp_paddr = '0;
  logic [DW-1:0] exp_pwdata = '0, exp_rdata = '0;
  logic [SW-1:0] exp_pstrb = '0;

  function automatic bit model_ready();
    return !m_busy || (m_k >= 2 && PREADY);
  endfunction

  always @(posedge PCLK) begin
    bit acc;
    acc = cmd_valid && model_ready();
    if (!PRESETn) begin
      m_busy = 0; m_k = 0; m_wait = 0;
      exp_psel = 0; exp_pen = 0; exp_pwrite = 0; exp_rv = 0; exp_err = 0;
      exp_paddr = '0; exp_pwdata = '0; exp_rdata = '0; exp_pstrb = '0;
    end else begin
      exp_rv = 0;
      if (m_busy) begin
        if (m_k == 1) m_k = 2;
        else if (PREADY) begin
          exp_rv = 1;
          exp_err = PSLVERR;
          if (m_cur.w) ref_mem[m_cur.a] = merge(ref_mem[m_cur.a], m_cur.d, m_cur.s);
          else exp_rdata = ref_mem[m_cur.a];
          m_busy = 0;
        end else begin
          m_wait++;
`ifdef APB_TIMEOUT_EN
          if (m_wait == TO) begin exp_rv = 1; exp_err = 1; m_busy = 0; end
`endif
        end
      end
      if (acc) begin
        m_cur = mk(cmd_write, cmd_addr, cmd_wdata, cmd_strb);
        m_busy = 1; m_k = 1; m_wait = 0;
        exp_paddr = cmd_addr; exp_pwrite = cmd_write; exp_pwdata = cmd_wdata;
        exp_pstrb = cmd_write ? cmd_strb : '0;
      end
      exp_psel = m_busy;
      exp_pen = m_busy && (m_k == 2);
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge PCLK) begin
    #1;
    check("PSEL", PSEL, exp_psel);
    check("PENABLE", PENABLE, exp_pen);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("cmd_ready", cmd_ready, model_ready());
    if (exp_psel) begin
      check("PADDR", PADDR, exp_paddr);
      check("PWRITE", PWRITE, exp_pwrite);
      check("PWDATA", PWDATA, exp_pwdata);
      check("PSTROBE", PSTROBE, exp_pstrb);
    end
  end

  // Observation for the directed literal checks.
  int rsp_count = 0, last_rsp_cyc = 0, acc_cycles = 0, psel_hi = 0;
  logic [DW-1:0] last_rsp_rdata = '0, setup_wdata = '0;
  logic [AW-1:0] setup_addr = '0;
  logic [SW-1:0] last_acc_strb = '0;
  logic last_rsp_err = 0;
  bit stable_ok = 1;

  always @(posedge PCLK) begin
    #1;
    if (PSEL) psel_hi++;
    if (PSEL && !PENABLE) begin
      acc_cycles = 0; setup_addr = PADDR; setup_wdata = PWDATA; stable_ok = 1;
    end
    if (PSEL && PENABLE) begin
      acc_cycles++;
      last_acc_strb = PSTROBE;
      if (PADDR !== setup_addr || PWDATA !== setup_wdata) stable_ok = 0;
    end
    if (rsp_valid) begin
      rsp_count++; last_rsp_cyc = cyc; last_rsp_rdata = rsp_rdata; last_rsp_err = rsp_err;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || cmd_valid || m_busy) && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check({name, "_drain"}, (n < budget), 1);
    @(negedge PCLK);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, p0, n;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge PCLK);
    check("reset_PSEL", PSEL, 0);
    check("reset_PENABLE", PENABLE, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_PADDR", PADDR, 0);
    check("reset_PSTROBE", PSTROBE, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;

    // Zero-wait write then read-back of the same word.
    base = rsp_count; p0 = psel_hi;
    cmd_q.push_back(mk(1'b1, 6'h05, 32'h5555_5555, 4'hF));
    wait_done("wr", 50);
    check("wr_latency", last_rsp_cyc - last_acc_cyc, 2);
    check("wr_psel_cycles", psel_hi - p0, 2);
    check("wr_access_cycles", acc_cycles, 1);
    check("wr_strobe", last_acc_strb, 4'hF);
    check("wr_err", last_rsp_err, 0);
    check("wr_rsp_count", rsp_count - base, 1);

    cmd_q.push_back(mk(1'b0, 6'h05, 32'h0, 4'hF));
    wait_done("rd", 50);
    check("rd_rdata", last_rsp_rdata, 32'h5555_5555);
    check("rd_strobe", last_acc_strb, 0);
    check("rd_latency", last_rsp_cyc - last_acc_cyc, 2);

    // Back-to-back burst at full rate.
    base = rsp_count; p0 = psel_hi; mark_first = 1;
    for (int i = 0; i < 50; i++) cmd_q.push_back(mk(1'b1, AW'(i), $urandom, SW'(4 - i)));
    wait_done("burst", 400);
    check("burst_rsp_count", rsp_count - base, 50);
    check("burst_cycles", last_rsp_cyc - first_acc_cyc, 100);
    check("burst_psel_cycles", psel_hi - p0, 100);

    // Three wait states with slave error.
    slave_mode = 1; slave_waits = 3; err_mode = 1;
    cmd_q.push_back(mk(1'b1, 6'h09, 32'hA5C3_0F1E, 4'h6));
    wait_done("wait", 50);
    check("wait_access_cycles", acc_cycles, 4);
    check("wait_stable", stable_ok, 1);
    check("wait_err", last_rsp_err, 1);
    check("wait_latency", last_rsp_cyc - last_acc_cyc, 5);
    slave_mode = 0; err_mode = 0;

    // Reset in the middle of an ACCESS wait.
    slave_mode = 3;
    cmd_q.push_back(mk(1'b0, 6'h05, 32'h0, 4'h0));
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin @(negedge PCLK); n++; end
    check("midrst_reach_access", (n < 20), 1);
    base = rsp_count;
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    check("midrst_PSEL", PSEL, 0);
    check("midrst_PENABLE", PENABLE, 0);
    check("midrst_PADDR", PADDR, 0);
    check("midrst_PWRITE", PWRITE, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge PCLK);
    check("midrst_no_rsp", rsp_count - base, 0);

    // Stuck slave: timeout abort or indefinite wait depending on build.
    base = rsp_count;
    cmd_q.push_back(mk(1'b0, 6'h05, 32'h0, 4'h0));
`ifdef APB_TIMEOUT_EN
    n = 0;
    while (rsp_count == base && n < 40) begin @(negedge PCLK); n++; end
    check("to_rsp_seen", rsp_count - base, 1);
    check("to_err", last_rsp_err, 1);
    check("to_access_cycles", acc_cycles, TO);
    check("to_rdata_kept", last_rsp_rdata, 0);
    check("to_psel_low", PSEL, 0);
`else
    repeat (100) @(negedge PCLK);
    check("stuck_in_access", PSEL && PENABLE, 1);
    check("stuck_no_rsp", rsp_count - base, 0);
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
`endif
    slave_mode = 0;
    repeat (2) @(negedge PCLK);

    // Randomised traffic against the model.
    slave_mode = 2; err_mode = 2; req_rate = 60;
    base = rsp_count;
    for (int i = 0; i < 300; i++)
      cmd_q.push_back(mk(1'($urandom), AW'($urandom), $urandom, SW'($urandom)));
    wait_done("random", 6000);
    check("random_rsp_count", rsp_count - base, 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
